// File: rtl/rf_sync_ctrl_pkg.sv
// Shared types and helpers for the register-file controller.
package rf_sync_ctrl_pkg;

  // Controller phase: CLEAR zeroes the array after reset, READY serves the core.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_ctrl_state_e;

  // Address width that stays at least one bit for degenerate sizes.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_sync_ctrl_if.sv
// Decode/writeback side bundle of the register-file controller.
interface rf_sync_ctrl_if #(
  parameter int width_p       = 32,
  parameter int addr_width_lp = 5
);

  logic                     ready_o;
  logic                     w_v_i;
  logic [addr_width_lp-1:0] w_addr_i;
  logic [width_p-1:0]       w_data_i;
  logic                     r0_v_i;
  logic [addr_width_lp-1:0] r0_addr_i;
  logic [width_p-1:0]       r0_data_o;
  logic                     r1_v_i;
  logic [addr_width_lp-1:0] r1_addr_i;
  logic [width_p-1:0]       r1_data_o;

  // Core pipeline side: issues requests, consumes read data.
  modport master (
    input  ready_o, r0_data_o, r1_data_o,
    output w_v_i, w_addr_i, w_data_i,
    output r0_v_i, r0_addr_i, r1_v_i, r1_addr_i
  );

  // Controller side.
  modport slave (
    output ready_o, r0_data_o, r1_data_o,
    input  w_v_i, w_addr_i, w_data_i,
    input  r0_v_i, r0_addr_i, r1_v_i, r1_addr_i
  );

endinterface

// File: rtl/bsg_mem_2r1w_sync.sv
// Two synchronous read ports, one write port. A read of an address written in
// the same cycle returns the previous contents; the controller bypasses that case.
module bsg_mem_2r1w_sync #(
  parameter int width_p                = 32,
  parameter int els_p                  = 32,
  parameter int read_write_same_addr_p = 0,
  parameter int addr_width_lp          = (els_p <= 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r0_v_i,
  input  logic [addr_width_lp-1:0] r0_addr_i,
  output logic [width_p-1:0]       r0_data_o,
  input  logic                     r1_v_i,
  input  logic [addr_width_lp-1:0] r1_addr_i,
  output logic [width_p-1:0]       r1_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;
  end

  // Registered reads; data holds when a port is not enabled.
  always_ff @(posedge clk_i) begin
    if (r0_v_i) r0_data_o <= mem_r[r0_addr_i];
    if (r1_v_i) r1_data_o <= mem_r[r1_addr_i];
  end

endmodule

// File: rtl/rf_sync_ctrl_read_port.sv
// One read port: captures request, resolves zero entry and same-cycle write
// bypass, and holds the last delivered value while idle.
module rf_sync_ctrl_read_port #(
  parameter int width_p       = 32,
  parameter int addr_width_lp = 5,
  parameter int zero_reg_p    = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  input  logic                     w_eff_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       mem_data_i,
  output logic [width_p-1:0]       r_data_o
);

  logic               rd_p0;
  logic               vld_p1;
  logic               zero_p1;
  logic               byp_p1;
  logic [width_p-1:0] byp_data_p1;
  logic [width_p-1:0] hold_p1;

  assign rd_p0 = en_i & r_v_i;

  // Request capture and hold register; the hold tracks whatever was last shown.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1      <= 1'b0;
      zero_p1     <= 1'b0;
      byp_p1      <= 1'b0;
      byp_data_p1 <= '0;
      hold_p1     <= '0;
    end else begin
      // ---- p0 -> p1: request, zero-entry and bypass flags ----
      vld_p1 <= rd_p0;
      if (rd_p0) begin
        zero_p1     <= (zero_reg_p != 0) && (r_addr_i == '0);
        byp_p1      <= w_eff_i && (w_addr_i == r_addr_i);
        byp_data_p1 <= w_data_i;
      end
      hold_p1 <= r_data_o;
    end
  end

  // Output select: idle ports replay the hold value so mem X never escapes.
  always_comb begin
    r_data_o = hold_p1;
    if (vld_p1) begin
      if (zero_p1)     r_data_o = '0;
      else if (byp_p1) r_data_o = byp_data_p1;
      else             r_data_o = mem_data_i;
    end
  end

endmodule

// File: rtl/rf_sync_ctrl.sv
// RV32I register-file controller: post-reset clear, zero entry, write-to-read
// bypass and idle hold around a 2R1W synchronous memory.
module rf_sync_ctrl
  import rf_sync_ctrl_pkg::*;
#(
  parameter int width_p      = 32,
  parameter int els_p        = 32,
  parameter int zero_reg_p   = 1,
  parameter int init_clear_p = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  rf_sync_ctrl_if.slave bus
);

  localparam int addr_width_lp = safe_clog2(els_p);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp-1:0] one_lp       = addr_width_lp'(1);

  rf_ctrl_state_e           state_r;
  logic [addr_width_lp-1:0] clr_cnt_r;
  logic                     ready_r;
  logic                     in_ready;
  logic                     clearing;
  logic                     w_eff;
  logic                     mem_w_v;
  logic [addr_width_lp-1:0] mem_w_addr;
  logic [width_p-1:0]       mem_w_data;
  logic [width_p-1:0]       mem_r0_data;
  logic [width_p-1:0]       mem_r1_data;

  assign in_ready = (state_r == READY);
  assign clearing = (state_r == CLEAR);

  // Controller FSM with clear counter; counter stops at the last entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= (init_clear_p != 0) ? CLEAR : READY;
      clr_cnt_r <= '0;
      ready_r   <= (init_clear_p == 0);
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_cnt_r == last_addr_lp) begin
            state_r <= READY;
            ready_r <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + one_lp;
          end
        end
        READY:   ready_r <= 1'b1;
        default: state_r <= READY;
      endcase
    end
  end

  assign bus.ready_o = ready_r;

  // Writes to the hardwired zero entry are dropped before reaching the array.
  assign w_eff = in_ready & bus.w_v_i
               & ~((zero_reg_p != 0) && (bus.w_addr_i == '0));

  assign mem_w_v    = clearing | w_eff;
  assign mem_w_addr = clearing ? clr_cnt_r : bus.w_addr_i;
  assign mem_w_data = clearing ? '0 : bus.w_data_i;

  bsg_mem_2r1w_sync #(
    .width_p                (width_p),
    .els_p                  (els_p),
    .read_write_same_addr_p (0),
    .addr_width_lp          (addr_width_lp)
  ) mem (
    .clk_i     (clk_i),
    .w_v_i     (mem_w_v),
    .w_addr_i  (mem_w_addr),
    .w_data_i  (mem_w_data),
    .r0_v_i    (in_ready & bus.r0_v_i),
    .r0_addr_i (bus.r0_addr_i),
    .r0_data_o (mem_r0_data),
    .r1_v_i    (in_ready & bus.r1_v_i),
    .r1_addr_i (bus.r1_addr_i),
    .r1_data_o (mem_r1_data)
  );

  rf_sync_ctrl_read_port #(
    .width_p       (width_p),
    .addr_width_lp (addr_width_lp),
    .zero_reg_p    (zero_reg_p)
  ) rp0 (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (in_ready),
    .r_v_i      (bus.r0_v_i),
    .r_addr_i   (bus.r0_addr_i),
    .w_eff_i    (w_eff),
    .w_addr_i   (bus.w_addr_i),
    .w_data_i   (bus.w_data_i),
    .mem_data_i (mem_r0_data),
    .r_data_o   (bus.r0_data_o)
  );

  rf_sync_ctrl_read_port #(
    .width_p       (width_p),
    .addr_width_lp (addr_width_lp),
    .zero_reg_p    (zero_reg_p)
  ) rp1 (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (in_ready),
    .r_v_i      (bus.r1_v_i),
    .r_addr_i   (bus.r1_addr_i),
    .w_eff_i    (w_eff),
    .w_addr_i   (bus.w_addr_i),
    .w_data_i   (bus.w_data_i),
    .mem_data_i (mem_r1_data),
    .r_data_o   (bus.r1_data_o)
  );

  // Out-of-range addresses only matter for non-power-of-two sizes.
  always_ff @(posedge clk_i) begin
    if (!reset_i && in_ready) begin
      assert (!bus.w_v_i  || int'(bus.w_addr_i)  < els_p);
      assert (!bus.r0_v_i || int'(bus.r0_addr_i) < els_p);
      assert (!bus.r1_v_i || int'(bus.r1_addr_i) < els_p);
    end
  end

endmodule

// File: tb/tb_rf_sync_ctrl.sv
// Bench for rf_sync_ctrl: directed scenarios plus a random phase, checked
// every cycle against an entry-level model of the register file.
module tb_rf_sync_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  rf_sync_ctrl_if #(.width_p(32), .addr_width_lp(5)) bus ();
  rf_sync_ctrl_if #(.width_p(32), .addr_width_lp(3)) bus2 ();

  rf_sync_ctrl #(.width_p(32), .els_p(32), .zero_reg_p(1), .init_clear_p(1)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  rf_sync_ctrl #(.width_p(32), .els_p(8), .zero_reg_p(0), .init_clear_p(0)) dut2 (
    .clk_i   (clk),
    .reset_i (rst2),
    .bus     (bus2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Entries as the core sees them; a read returns the entry value after this
  // cycle's write, and the controller is blind for 32 cycles after any reset.
  logic [31:0] mdl_mem [32];
  int          clr_left = 32;
  logic [31:0] exp_r0 = '0;
  logic [31:0] exp_r1 = '0;
  logic        exp_ready;
  bit          chk_en = 1'b0;

  assign exp_ready = (clr_left == 0);

  function automatic logic [31:0] entry_after_write(input logic [4:0] a);
    if (a != 5'd0 && bus.w_v_i && bus.w_addr_i == a) return bus.w_data_i;
    return mdl_mem[a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl_mem[i] <= '0;
      clr_left <= 32;
      exp_r0   <= '0;
      exp_r1   <= '0;
      chk_en   <= 1'b1;
    end else if (clr_left > 0) begin
      clr_left <= clr_left - 1;
    end else begin
      if (bus.w_v_i && bus.w_addr_i != 5'd0) mdl_mem[bus.w_addr_i] <= bus.w_data_i;
      if (bus.r0_v_i) exp_r0 <= entry_after_write(bus.r0_addr_i);
      if (bus.r1_v_i) exp_r1 <= entry_after_write(bus.r1_addr_i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_o", {31'd0, bus.ready_o}, {31'd0, exp_ready});
      check("r0_data_o", bus.r0_data_o, exp_r0);
      check("r1_data_o", bus.r1_data_o, exp_r1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.w_v_i = 1'b0; bus.r0_v_i = 1'b0; bus.r1_v_i = 1'b0;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r0v, input logic [4:0] r0a,
                       input logic r1v, input logic [4:0] r1a);
    bus.w_v_i = wv;   bus.w_addr_i = wa;   bus.w_data_i = wd;
    bus.r0_v_i = r0v; bus.r0_addr_i = r0a;
    bus.r1_v_i = r1v; bus.r1_addr_i = r1a;
  endtask

  task automatic wait_ready_count(input string name);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check(name, {31'd0, bus.ready_o}, {31'd0, (i == 32)});
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    bus2.w_v_i = 1'b0; bus2.w_addr_i = '0; bus2.w_data_i = '0;
    bus2.r0_v_i = 1'b0; bus2.r0_addr_i = '0; bus2.r1_v_i = 1'b0; bus2.r1_addr_i = '0;

    // Reset state of both instances.
    @(negedge clk); @(negedge clk);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("rst_r0", bus.r0_data_o, 32'd0);
    check("rst_r1", bus.r1_data_o, 32'd0);
    check("nz_rst_ready", {31'd0, bus2.ready_o}, 32'd1);
    check("nz_rst_r0", bus2.r0_data_o, 32'd0);
    rst = 1'b0; rst2 = 1'b0;

    // Clear takes exactly 32 cycles, then every entry reads zero.
    wait_ready_count("clear_ready");
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      @(negedge clk);
      check("clear_r0", bus.r0_data_o, 32'd0);
      check("clear_r1", bus.r1_data_o, 32'd0);
    end
    idle();

    // Reset mid-clear restarts; requests during clear are ignored.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("clr10_ready", {31'd0, bus.ready_o}, 32'd0);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i <= 20) drive(1'b1, 5'd2, 32'hFFFF, 1'b1, 5'd2, 1'b1, 5'd2);
      else idle();
      @(negedge clk);
      check("restart_ready", {31'd0, bus.ready_o}, {31'd0, (i == 32)});
      check("clear_hold_r0", bus.r0_data_o, 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0);
    @(negedge clk); idle();
    check("ignored_write", bus.r0_data_o, 32'd0);

    // Same-cycle write and dual read of entry 5.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5);
    @(negedge clk); idle();
    check("bypass_r0", bus.r0_data_o, 32'hDEADBEEF);
    check("bypass_r1", bus.r1_data_o, 32'hDEADBEEF);
    check("model_bypass", exp_r0, 32'hDEADBEEF);

    // Entry 0 is hardwired to zero.
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    check("zero_same", bus.r0_data_o, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    @(negedge clk); idle();
    check("zero_next", bus.r0_data_o, 32'd0);

    // Hold: later write does not disturb an idle port.
    drive(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    check("read_after_write", bus.r0_data_o, 32'hA5);
    drive(1'b1, 5'd7, 32'hFF, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk); idle();
    check("hold_1", bus.r0_data_o, 32'hA5);
    @(negedge clk);
    check("hold_2", bus.r0_data_o, 32'hA5);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7);
    @(negedge clk);
    check("hold_r1_new", bus.r1_data_o, 32'hFF);
    check("hold_3", bus.r0_data_o, 32'hA5);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    @(negedge clk); idle();
    check("hold_release", bus.r0_data_o, 32'hFF);
    check("model_hold", exp_r0, 32'hFF);

    // Random traffic with occasional resets; model compare covers it.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
            $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      @(negedge clk);
    end
    rst = 1'b0; idle();
    @(negedge clk);

    // zero_reg_p=0: entry 0 is an ordinary register, bypass included.
    bus2.w_v_i = 1'b1; bus2.w_addr_i = 3'd0; bus2.w_data_i = 32'h1234;
    @(negedge clk);
    bus2.w_v_i = 1'b0; bus2.r0_v_i = 1'b1; bus2.r0_addr_i = 3'd0;
    @(negedge clk);
    check("nz_entry0", bus2.r0_data_o, 32'h1234);
    bus2.w_v_i = 1'b1; bus2.w_addr_i = 3'd0; bus2.w_data_i = 32'h5678;
    bus2.r1_v_i = 1'b1; bus2.r1_addr_i = 3'd0;
    @(negedge clk);
    bus2.w_v_i = 1'b0; bus2.r0_v_i = 1'b0; bus2.r1_v_i = 1'b0;
    check("nz_bypass_r0", bus2.r0_data_o, 32'h5678);
    check("nz_bypass_r1", bus2.r1_data_o, 32'h5678);
    @(negedge clk);
    check("nz_hold", bus2.r0_data_o, 32'h5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
